// File: rtl/multi_dataflow_package.sv
// Shared types for the multi_dataflow engine: adapter FSM states and the
// control/flag bundles exchanged between the control FSM and the engine.
`timescale 1ns/1ps
package multi_dataflow_package;

  localparam int ENG_N_COEFF   = 4;
  localparam int ENG_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } kernel_adapter_state_t;

  // FSM -> engine
  typedef struct packed {
    logic                                start;
    logic [ENG_CNT_WIDTH-1:0]            cnt_limit;
    logic [ENG_N_COEFF-1:0][31:0]        coeff;
  } ctrl_engine_t;

  // engine -> FSM
  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [ENG_CNT_WIDTH-1:0] cnt;
    logic                     err;
  } flags_engine_t;

endpackage

// File: rtl/multi_dataflow_beat_counter.sv
// Saturating outStream0 beat counter with limit compare and
// beat-past-limit detect.
`timescale 1ns/1ps
module multi_dataflow_beat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 clr_i,     // reset or soft clear
  input  logic                 init_i,    // job start: restart from 0
  input  logic                 en_i,      // counting window open
  input  logic                 beat_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 eq_o,      // next count equals limit
  output logic                 reach_o,   // next count at or past limit
  output logic                 over_o     // beat arrived with count already at limit
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 inc;

  // next count: clear on init, +1 per counted beat, stick at all-ones
  always_comb begin
    inc   = en_i & beat_i;
    cnt_d = cnt_q;
    if (init_i)
      cnt_d = '0;
    else if (inc && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // Compare against the post-beat count so a beat and ap_done on the same
  // edge completes the job without flagging a short count.
  always_comb begin
    eq_o    = (cnt_d == limit_i);
    reach_o = (cnt_d >= limit_i);
    over_o  = inc & (cnt_q >= limit_i);
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_dataflow_kernel_adapter.sv
// Adapter between the multi_dataflow control FSM and the HLS kernel:
// coefficient latch, ap_start/ap_ready/ap_done handshake, beat accounting.
`timescale 1ns/1ps
module multi_dataflow_kernel_adapter
  import multi_dataflow_package::*;
#(
  parameter int N_COEFF   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      cnt_limit_i,
  input  logic [N_COEFF-1:0][31:0]  coeff_i,
  output logic [N_COEFF-1:0][31:0]  coeff_o,
  output logic                      ap_start_o,
  input  logic                      ap_ready_i,
  input  logic                      ap_done_i,
  input  logic                      out_valid_i,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      cnt_o,
  output logic                      err_o
);

  kernel_adapter_state_t     state_q, state_d;
  logic [CNT_WIDTH-1:0]      limit_q, limit_d;
  logic                      done_seen_q, done_seen_d;
  logic                      err_q, err_d;
  logic [N_COEFF-1:0][31:0]  coeff_q, coeff_d;
  logic                      ap_start_q, ap_start_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic clr, init, cnt_en, beat;
  logic cnt_eq, cnt_reach, cnt_over, done_in;

  assign clr    = rst_i | clear_i;
  assign beat   = out_valid_i & out_ready_i;
  assign cnt_en = (state_q == START) || (state_q == RUN);

  multi_dataflow_beat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk_i   (clk_i),
    .clr_i   (clr),
    .init_i  (init),
    .en_i    (cnt_en),
    .beat_i  (beat),
    .limit_i (limit_q),
    .cnt_o   (cnt_o),
    .eq_o    (cnt_eq),
    .reach_o (cnt_reach),
    .over_o  (cnt_over)
  );

  // Next-state, latch and flag logic. ap_done is only taken in RUN, or in
  // START on the same cycle the kernel accepts ap_start.
  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    done_seen_d = done_seen_q;
    err_d       = err_q;
    coeff_d     = coeff_q;
    init        = 1'b0;
    done_in     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = LATCH;
          limit_d     = cnt_limit_i;
          err_d       = 1'b0;
          done_seen_d = 1'b0;
          init        = 1'b1;
        end
      end
      LATCH: begin
        coeff_d = coeff_i;
        state_d = START;
      end
      START: begin
        if (ap_ready_i) begin
          state_d = RUN;
          done_in = ap_done_i;
        end
      end
      RUN: begin
        done_in = ap_done_i;
        // a surplus beat leaves cnt past the limit; ap_done still completes
        if ((done_seen_q || ap_done_i) && (cnt_reach || cnt_eq))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done_in) done_seen_d = 1'b1;
    if (cnt_over || (done_in && !cnt_reach)) err_d = 1'b1;
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    ap_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // FSM and output registers; reset and soft clear abort any job silently
  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q     <= IDLE;
      limit_q     <= '0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
      coeff_q     <= '0;
      ap_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      done_seen_q <= done_seen_d;
      err_q       <= err_d;
      coeff_q     <= coeff_d;
      ap_start_q  <= ap_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign coeff_o    = coeff_q;
  assign ap_start_o = ap_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
